// File: rtl/am2910_seq_ctrl_pkg.sv
// rtl/am2910_seq_ctrl_pkg.sv - shared opcodes, slice source encodings and condition helper
package am2910_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_JZ   = 3'd0,
      OP_CJS  = 3'd1,
      OP_JMAP = 3'd2,
      OP_CJP  = 3'd3,
      OP_PUSH = 3'd4,
      OP_CRTN = 3'd5,
      OP_RFCT = 3'd6,
      OP_CONT = 3'd7
   } op_e;

   localparam logic [1:0] SEL_UPC = 2'b00;
   localparam logic [1:0] SEL_D   = 2'b11;

   // A disabled condition always passes; an enabled one passes on CC_N low.
   function automatic logic cond_pass(input logic cc_n, input logic ccen_n);
      return ccen_n | ~cc_n;
   endfunction

endpackage

// File: rtl/am2910_seq_ctrl_seq_stack.sv
// rtl/am2910_seq_ctrl_seq_stack.sv - DEPTH x W subroutine/loop LIFO with saturating push
module seq_stack #(
   parameter int W     = 12,
   parameter int DEPTH = 5,
   localparam int SPW  = $clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           push,
   input  logic           pop,
   input  logic           clr,
   input  logic [W-1:0]   din,
   output logic [W-1:0]   tos,
   output logic [SPW-1:0] sp,
   output logic           full
);

   localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
   localparam logic [SPW-1:0] SP_LAST = SPW'(DEPTH - 1);
   localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

   logic [W-1:0]   r_mem [DEPTH];
   logic [SPW-1:0] r_sp;
   logic [SPW-1:0] w_wr_idx;
   logic           w_full;

   assign w_full   = (r_sp == SP_FULL);
   // A push onto a full stack replaces the top entry instead of growing.
   assign w_wr_idx = w_full ? SP_LAST : r_sp;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sp <= '0;
         for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      end else if (clr) begin
         r_sp <= '0;
      end else if (push) begin
         r_mem[w_wr_idx] <= din;
         if (!w_full) r_sp <= r_sp + SP_ONE;
      end else if (pop && r_sp != '0) begin
         r_sp <= r_sp - SP_ONE;
      end
   end

   assign tos  = (r_sp == '0) ? '0 : r_mem[r_sp - SP_ONE];
   assign sp   = r_sp;
   assign full = w_full;

endmodule

// File: rtl/am2910_seq_ctrl.sv
// rtl/am2910_seq_ctrl.sv - Am2910-style next-address controller driving Am2909 slices
module am2910_seq_ctrl
   import am2910_seq_ctrl_pkg::*;
#(
   parameter int W     = 12,
   parameter int DEPTH = 5
) (
   input  logic         CP,
   input  logic         RST_N,
   input  logic [2:0]   I,
   input  logic         CC_N,
   input  logic         CCEN_N,
   input  logic [W-1:0] BR,
   input  logic [W-1:0] MAP,
   input  logic [W-1:0] Y_IN,
   output logic [1:0]   S,
   output logic         ZERO,
   output logic         OE,
   output logic         RE,
   output logic         C,
   output logic [W-1:0] D_OUT,
   output logic         FULL_N
);

   localparam int SPW = $clog2(DEPTH + 1);
   localparam logic [W-1:0] W_ONE = W'(1);

   logic [W-1:0]   r_cnt;
   logic           w_pass;
   logic [1:0]     w_sel;
   logic           w_zero;
   logic [W-1:0]   w_dout;
   logic           w_push;
   logic           w_pop_req;
   logic           w_clr;
   logic           w_cnt_ld;
   logic           w_cnt_dec;
   logic [W-1:0]   w_tos;
   logic [SPW-1:0] w_sp;
   logic           w_full;

   assign w_pass = cond_pass(CC_N, CCEN_N);

   always_comb begin
      w_sel     = SEL_UPC;
      w_zero    = 1'b1;
      w_dout    = BR;
      w_push    = 1'b0;
      w_pop_req = 1'b0;
      w_clr     = 1'b0;
      w_cnt_ld  = 1'b0;
      w_cnt_dec = 1'b0;
      if (!RST_N) begin
         w_zero = 1'b0;
         w_dout = '0;
      end else begin
         case (op_e'(I))
            OP_JZ: begin
               w_zero = 1'b0;
               w_clr  = 1'b1;
            end
            OP_CJS: if (w_pass) begin
               w_sel  = SEL_D;
               w_push = 1'b1;
            end
            OP_JMAP: begin
               w_sel  = SEL_D;
               w_dout = MAP;
            end
            OP_CJP: if (w_pass) w_sel = SEL_D;
            OP_PUSH: begin
               w_push   = 1'b1;
               w_cnt_ld = w_pass;
            end
            OP_CRTN: if (w_pass) begin
               w_sel     = SEL_D;
               w_dout    = w_tos;
               w_pop_req = 1'b1;
            end
            // Loop back to TOS until the counter is exhausted, then drop the loop address.
            OP_RFCT: if (r_cnt != '0) begin
               w_sel     = SEL_D;
               w_dout    = w_tos;
               w_cnt_dec = 1'b1;
            end else begin
               w_pop_req = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CP) begin
      if (!RST_N)         r_cnt <= '0;
      else if (w_cnt_ld)  r_cnt <= BR;
      else if (w_cnt_dec) r_cnt <= r_cnt - W_ONE;
   end

   seq_stack #(.W(W), .DEPTH(DEPTH)) u_stack (
      .clk   (CP),
      .rst_n (RST_N),
      .push  (w_push),
      .pop   (w_pop_req && (w_sp != '0)),
      .clr   (w_clr),
      .din   (Y_IN + W_ONE),
      .tos   (w_tos),
      .sp    (w_sp),
      .full  (w_full)
   );

   assign S      = w_sel;
   assign ZERO   = w_zero;
   assign D_OUT  = w_dout;
   assign FULL_N = ~w_full;
   assign OE     = 1'b0;
   assign RE     = 1'b1;
   assign C      = 1'b1;

endmodule

// File: tb/tb_am2910_seq_ctrl.sv
// tb/tb_am2910_seq_ctrl.sv - scoreboard bench with a queue-based reference model
module tb_am2910_seq_ctrl;

   localparam int W     = 12;
   localparam int DEPTH = 5;

   logic          CP = 1'b0;
   logic          RST_N = 1'b0;
   logic [2:0]    I = 3'd7;
   logic          CC_N = 1'b1;
   logic          CCEN_N = 1'b1;
   logic [W-1:0]  BR = '0;
   logic [W-1:0]  MAP = '0;
   logic [W-1:0]  Y_IN = '0;
   logic [1:0]    S;
   logic          ZERO;
   logic          OE;
   logic          RE;
   logic          C;
   logic [W-1:0]  D_OUT;
   logic          FULL_N;

   am2910_seq_ctrl #(.W(W), .DEPTH(DEPTH)) dut (
      .CP(CP), .RST_N(RST_N), .I(I), .CC_N(CC_N), .CCEN_N(CCEN_N),
      .BR(BR), .MAP(MAP), .Y_IN(Y_IN),
      .S(S), .ZERO(ZERO), .OE(OE), .RE(RE), .C(C), .D_OUT(D_OUT), .FULL_N(FULL_N)
   );

   always #5 CP = ~CP;

   typedef struct {
      logic [1:0]   s;
      logic         zero;
      logic [W-1:0] d;
      logic         full_n;
   } exp_t;

   exp_t          exp_q[$];
   logic [W-1:0]  stk[$];
   int            cnt = 0;
   int            errors = 0;
   int            checks = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_push(input logic [W-1:0] v);
      if (stk.size() == DEPTH) stk[DEPTH-1] = v;
      else stk.push_back(v);
   endtask

   task automatic step(input logic rn, input logic [2:0] op, input logic ccn, input logic cenn,
                       input logic [W-1:0] br, input logic [W-1:0] mp, input logic [W-1:0] y);
      exp_t         e;
      logic         pass;
      logic [W-1:0] tos;
      @(posedge CP);
      #1;
      RST_N = rn; I = op; CC_N = ccn; CCEN_N = cenn; BR = br; MAP = mp; Y_IN = y;
      pass     = cenn | ~ccn;
      tos      = (stk.size() != 0) ? stk[stk.size()-1] : '0;
      e.s      = 2'b00;
      e.zero   = 1'b1;
      e.d      = br;
      e.full_n = (stk.size() != DEPTH);
      if (!rn) begin
         e.zero = 1'b0;
         e.d    = '0;
         stk.delete();
         cnt = 0;
      end else begin
         case (op)
            3'd0: begin e.zero = 1'b0; stk.delete(); end
            3'd1: if (pass) begin e.s = 2'b11; model_push(y + 12'd1); end
            3'd2: begin e.s = 2'b11; e.d = mp; end
            3'd3: if (pass) e.s = 2'b11;
            3'd4: begin model_push(y + 12'd1); if (pass) cnt = int'(br); end
            3'd5: if (pass) begin
               e.s = 2'b11; e.d = tos;
               if (stk.size() != 0) void'(stk.pop_back());
            end
            3'd6: if (cnt != 0) begin
               e.s = 2'b11; e.d = tos; cnt = cnt - 1;
            end else if (stk.size() != 0) begin
               void'(stk.pop_back());
            end
            default: ;
         endcase
      end
      exp_q.push_back(e);
   endtask

   always @(negedge CP) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("S",      32'(S),      32'(e.s));
         check("ZERO",   32'(ZERO),   32'(e.zero));
         check("D_OUT",  32'(D_OUT),  32'(e.d));
         check("FULL_N", 32'(FULL_N), 32'(e.full_n));
         check("OE",     32'(OE),     32'd0);
         check("RE",     32'(RE),     32'd1);
         check("C",      32'(C),      32'd1);
      end
   end

   initial begin
      // reset with a taken CJS pending, then release
      step(0, 3'd1, 0, 0, 12'h123, 12'h0, 12'h050);
      step(0, 3'd1, 0, 0, 12'h123, 12'h0, 12'h050);
      step(1, 3'd7, 1, 1, 12'h055, 12'h0, 12'h000);
      // call and return
      step(1, 3'd1, 0, 0, 12'h200, 12'h0, 12'h010);
      step(1, 3'd7, 1, 1, 12'h000, 12'h0, 12'h200);
      step(1, 3'd5, 0, 0, 12'h000, 12'h0, 12'h201);
      step(1, 3'd5, 0, 0, 12'h000, 12'h0, 12'h011);
      // condition fail, then condition disabled
      step(1, 3'd1, 1, 0, 12'h300, 12'h0, 12'h020);
      step(1, 3'd3, 1, 0, 12'h301, 12'h0, 12'h021);
      step(1, 3'd5, 1, 0, 12'h302, 12'h0, 12'h022);
      step(1, 3'd1, 1, 1, 12'h300, 12'h0, 12'h020);
      step(1, 3'd3, 1, 1, 12'h301, 12'h0, 12'h300);
      step(1, 3'd5, 1, 1, 12'h302, 12'h0, 12'h301);
      // counted loop
      step(1, 3'd4, 0, 0, 12'h003, 12'h0, 12'h040);
      for (int k = 0; k < 4; k++) step(1, 3'd6, 1, 1, 12'h000, 12'h0, 12'h041);
      step(1, 3'd5, 0, 0, 12'h000, 12'h0, 12'h000);
      // fill past the top, then drain past the bottom
      for (int k = 1; k <= 6; k++) step(1, 3'd4, 1, 0, 12'h0, 12'h0, 12'(k));
      step(1, 3'd7, 1, 1, 12'h0, 12'h0, 12'h0);
      for (int k = 0; k < 6; k++) step(1, 3'd5, 0, 0, 12'h0, 12'h0, 12'h0);
      step(1, 3'd7, 1, 1, 12'h0, 12'h0, 12'h0);
      // JMAP, then JZ leaves the counter alone
      step(1, 3'd2, 1, 0, 12'h111, 12'hABC, 12'h0);
      step(1, 3'd4, 0, 0, 12'h002, 12'h0, 12'h060);
      step(1, 3'd4, 1, 0, 12'h000, 12'h0, 12'h061);
      step(1, 3'd4, 1, 0, 12'h000, 12'h0, 12'h062);
      step(1, 3'd0, 1, 1, 12'h0AA, 12'h0, 12'h0);
      step(1, 3'd6, 1, 1, 12'h0BB, 12'h0, 12'h0);
      step(1, 3'd7, 1, 1, 12'h0CC, 12'h0, 12'h0);
      // randomized traffic
      for (int k = 0; k < 600; k++) begin
         logic [2:0]   op;
         logic [W-1:0] br;
         op = 3'($urandom_range(0, 7));
         if (op == 3'd0 && $urandom_range(0, 3) != 0) op = 3'd7;
         br = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 4)) : 12'($urandom);
         step(($urandom_range(0, 79) != 0), op, 1'($urandom), 1'($urandom),
              br, 12'($urandom), 12'($urandom));
      end
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge CP);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
